// File: rtl/lc3_fetch_bus_sequencer_pkg.sv
// rtl/lc3_fetch_bus_sequencer_pkg.sv - shared types and constants for the LC-3 fetch/bus sequencer
package lc3_fetch_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_FETCH2 = 3'd2,
    ST_FETCH3 = 3'd3,
    ST_DECODE = 3'd4,
    ST_EXEC   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  // Bit positions inside a {MARMUX, ALU, MDR, PC} gate vector
  localparam int GATE_MARMUX = 3;
  localparam int GATE_ALU    = 2;
  localparam int GATE_MDR    = 1;
  localparam int GATE_PC     = 0;

  localparam logic [1:0] PCMUX_PC_PLUS1 = 2'b00;

endpackage

// File: rtl/lc3_fetch_bus_sequencer_if.sv
// rtl/lc3_fetch_bus_sequencer_if.sv - control-unit side handshake and datapath bus controls
interface lc3_fetch_bus_sequencer_if;
  logic        i_Start;
  logic        i_Halt;
  logic        i_Mem_R;
  logic [3:0]  i_Exec_Gate;
  logic        i_Exec_Done;
  logic        GateMARMUX;
  logic        GateALU;
  logic        GateMDR;
  logic        GatePC;
  logic        o_LD_MAR;
  logic        o_LD_PC;
  logic        o_LD_MDR;
  logic        o_LD_IR;
  logic        o_MIO_EN;
  logic [1:0]  o_PCMux_Sel;
  logic        o_Decode;
  logic        o_Bus_Conflict;
  logic        o_Fault;
  logic [15:0] o_Instr_Count;

  // The sequencer owns the bus gates, so it takes the master view
  modport master (
    input  i_Start, i_Halt, i_Mem_R, i_Exec_Gate, i_Exec_Done,
    output GateMARMUX, GateALU, GateMDR, GatePC,
    output o_LD_MAR, o_LD_PC, o_LD_MDR, o_LD_IR, o_MIO_EN, o_PCMux_Sel,
    output o_Decode, o_Bus_Conflict, o_Fault, o_Instr_Count
  );

  modport slave (
    output i_Start, i_Halt, i_Mem_R, i_Exec_Gate, i_Exec_Done,
    input  GateMARMUX, GateALU, GateMDR, GatePC,
    input  o_LD_MAR, o_LD_PC, o_LD_MDR, o_LD_IR, o_MIO_EN, o_PCMux_Sel,
    input  o_Decode, o_Bus_Conflict, o_Fault, o_Instr_Count
  );
endinterface

// File: rtl/lc3_fetch_bus_sequencer_gate_priority.sv
// rtl/lc3_fetch_bus_sequencer_gate_priority.sv - 4-bit fixed-priority one-hot filter with multi-request flag
module lc3_gate_priority (
  input  logic [3:0] req_i,
  output logic [3:0] grant_o,
  output logic       multi_o
);

  always_comb begin
    grant_o = 4'b0000;
    if (req_i[3])      grant_o[3] = 1'b1;
    else if (req_i[2]) grant_o[2] = 1'b1;
    else if (req_i[1]) grant_o[1] = 1'b1;
    else if (req_i[0]) grant_o[0] = 1'b1;
  end

  // Clearing the lowest set bit leaves something only when two or more were set
  assign multi_o = |(req_i & (req_i - 4'd1));

endmodule

// File: rtl/lc3_fetch_bus_sequencer.sv
// rtl/lc3_fetch_bus_sequencer.sv - LC-3 fetch sequencing and datapath bus ownership
module lc3_fetch_bus_sequencer
  import lc3_fetch_bus_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  lc3_fetch_bus_sequencer_if.master   bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
  logic                halt_q, halt_d, halt_now;
  logic                conflict_q, conflict_d;
  logic [15:0]         instr_count_q, instr_count_d;

  logic [3:0]          exec_grant;
  logic                exec_multi;
  logic [3:0]          gates;
  logic                ld_mar, ld_pc, ld_mdr, ld_ir, mio_en, decode;

  lc3_gate_priority u_gate_priority (
    .req_i   (bus.i_Exec_Gate),
    .grant_o (exec_grant),
    .multi_o (exec_multi)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      halt_q        <= 1'b0;
      conflict_q    <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      halt_q        <= halt_d;
      conflict_q    <= conflict_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign wait_inc = wait_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    conflict_d    = 1'b0;
    instr_count_d = instr_count_q;
    // A halt raised in the final EXEC cycle still stops after this instruction
    halt_now      = halt_q | ((state_q != ST_IDLE) & bus.i_Halt);
    halt_d        = halt_now;

    case (state_q)
      ST_IDLE:   if (bus.i_Start) state_d = ST_FETCH1;
      ST_FETCH1: begin
        state_d = ST_FETCH2;
        wait_d  = '0;
      end
      ST_FETCH2: begin
        wait_d = wait_inc;
        if (bus.i_Mem_R) begin
          state_d = ST_FETCH3;
          wait_d  = '0;
        end else if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = ST_FAULT;
        end
      end
      ST_FETCH3: begin
        instr_count_d = instr_count_q + 16'd1;
        state_d       = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        conflict_d = exec_multi;
        if (bus.i_Exec_Done) state_d = halt_now ? ST_IDLE : ST_FETCH1;
      end
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) halt_d = 1'b0;
  end

  always_comb begin
    gates  = 4'b0000;
    ld_mar = 1'b0;
    ld_pc  = 1'b0;
    ld_mdr = 1'b0;
    ld_ir  = 1'b0;
    mio_en = 1'b0;
    decode = 1'b0;
    case (state_q)
      ST_FETCH1: begin
        gates[GATE_PC] = 1'b1;
        ld_mar         = 1'b1;
        ld_pc          = 1'b1;
      end
      ST_FETCH2: begin
        mio_en = 1'b1;
        ld_mdr = 1'b1;
      end
      ST_FETCH3: begin
        gates[GATE_MDR] = 1'b1;
        ld_ir           = 1'b1;
      end
      ST_DECODE: decode = 1'b1;
      ST_EXEC:   gates  = exec_grant;
      default:   ;
    endcase
  end

  assign bus.GateMARMUX     = gates[GATE_MARMUX];
  assign bus.GateALU        = gates[GATE_ALU];
  assign bus.GateMDR        = gates[GATE_MDR];
  assign bus.GatePC         = gates[GATE_PC];
  assign bus.o_LD_MAR       = ld_mar;
  assign bus.o_LD_PC        = ld_pc;
  assign bus.o_LD_MDR       = ld_mdr;
  assign bus.o_LD_IR        = ld_ir;
  assign bus.o_MIO_EN       = mio_en;
  assign bus.o_PCMux_Sel    = PCMUX_PC_PLUS1;
  assign bus.o_Decode       = decode;
  assign bus.o_Bus_Conflict = conflict_q;
  assign bus.o_Fault        = (state_q == ST_FAULT);
  assign bus.o_Instr_Count  = instr_count_q;

endmodule

// File: tb/tb_lc3_fetch_bus_sequencer.sv
// tb/tb_lc3_fetch_bus_sequencer.sv - bench for lc3_fetch_bus_sequencer
module tb_lc3_fetch_bus_sequencer;

  localparam int TIMEOUT = 15;

  // Output vector: {GM, GA, GMDR, GPC, LDMAR, LDPC, LDMDR, LDIR, MIO, PCMUX[1:0], DEC, CONF, FAULT}
  localparam logic [13:0] E_F1      = 14'h0700;
  localparam logic [13:0] E_F2      = 14'h00A0;
  localparam logic [13:0] E_F3      = 14'h0840;
  localparam logic [13:0] E_DEC     = 14'h0004;
  localparam logic [13:0] E_ALU     = 14'h1000;
  localparam logic [13:0] E_PC_CONF = 14'h0402;
  localparam logic [13:0] E_FAULT   = 14'h0001;

  typedef enum int {M_IDLE, M_F1, M_F2, M_F3, M_DEC, M_EXEC, M_FAULT} mphase_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_f = 1'b1;
  always #5 clk = ~clk;

  lc3_fetch_bus_sequencer_if bus ();
  lc3_fetch_bus_sequencer_if busf ();

  lc3_fetch_bus_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  lc3_fetch_bus_sequencer #(.MEM_TIMEOUT(3)) dut_f (
    .i_Clk (clk),
    .i_Rst (rst_f),
    .bus   (busf)
  );

  logic [13:0] act_vec, act_vec_f;
  assign act_vec = {bus.GateMARMUX, bus.GateALU, bus.GateMDR, bus.GatePC,
                    bus.o_LD_MAR, bus.o_LD_PC, bus.o_LD_MDR, bus.o_LD_IR, bus.o_MIO_EN,
                    bus.o_PCMux_Sel, bus.o_Decode, bus.o_Bus_Conflict, bus.o_Fault};
  assign act_vec_f = {busf.GateMARMUX, busf.GateALU, busf.GateMDR, busf.GatePC,
                      busf.o_LD_MAR, busf.o_LD_PC, busf.o_LD_MDR, busf.o_LD_IR, busf.o_MIO_EN,
                      busf.o_PCMux_Sel, busf.o_Decode, busf.o_Bus_Conflict, busf.o_Fault};

  int n_checks = 0;
  int n_fail   = 0;
  bit f_done   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: which fetch phase we are in, cycles spent waiting, halt request, counters
  mphase_t     m_ph;
  int          m_wait;
  bit          m_halt;
  bit          m_conf;
  logic [15:0] m_count;

  task automatic model_reset();
    m_ph = M_IDLE; m_wait = 0; m_halt = 1'b0; m_conf = 1'b0; m_count = 16'd0;
  endtask

  function automatic logic [13:0] model_vec(input mphase_t ph, input logic [3:0] g, input bit conf);
    logic [13:0] v;
    bit found;
    v = '0;
    found = 1'b0;
    case (ph)
      M_F1:    v = E_F1;
      M_F2:    v = E_F2;
      M_F3:    v = E_F3;
      M_DEC:   v = E_DEC;
      M_FAULT: v = E_FAULT;
      M_EXEC: begin
        for (int b = 3; b >= 0; b--) begin
          if (g[b] && !found) begin
            v[10 + b] = 1'b1;
            found = 1'b1;
          end
        end
      end
      default: v = '0;
    endcase
    v[1] = conf;
    return v;
  endfunction

  task automatic model_step();
    bit halt_now;
    halt_now = m_halt || (m_ph != M_IDLE && bus.i_Halt);
    m_conf = (m_ph == M_EXEC) && ($countones(bus.i_Exec_Gate) > 1);
    case (m_ph)
      M_IDLE: if (bus.i_Start) m_ph = M_F1;
      M_F1: begin m_ph = M_F2; m_wait = 0; end
      M_F2: begin
        m_wait++;
        if (bus.i_Mem_R) m_ph = M_F3;
        else if (m_wait == TIMEOUT) m_ph = M_FAULT;
      end
      M_F3: begin m_count = m_count + 16'd1; m_ph = M_DEC; end
      M_DEC: m_ph = M_EXEC;
      M_EXEC: if (bus.i_Exec_Done) m_ph = halt_now ? M_IDLE : M_F1;
      default: ;
    endcase
    m_halt = (m_ph == M_IDLE) ? 1'b0 : halt_now;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      check("outputs", 32'(act_vec), 32'(model_vec(m_ph, bus.i_Exec_Gate, m_conf)));
      check("instr_count", 32'(bus.o_Instr_Count), 32'(m_count));
      check("gates_onehot0", 32'($onehot0(act_vec[13:10])), 32'd1);
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Fault path on the short-timeout instance
  initial begin
    busf.i_Start = 0; busf.i_Halt = 0; busf.i_Mem_R = 0; busf.i_Exec_Gate = 0; busf.i_Exec_Done = 0;
    repeat (2) @(posedge clk);
    #1 rst_f = 1'b0;
    busf.i_Start = 1'b1;
    tick(); busf.i_Start = 1'b0; #1 check("f_fetch1", 32'(act_vec_f), 32'(E_F1));
    for (int i = 0; i < 3; i++) begin
      tick(); #1 check("f_fetch2_wait", 32'(act_vec_f), 32'(E_F2));
    end
    tick(); #1 check("f_fault_entry", 32'(act_vec_f), 32'(E_FAULT));
    busf.i_Mem_R = 1'b1; busf.i_Start = 1'b1; busf.i_Exec_Gate = 4'hF; busf.i_Exec_Done = 1'b1;
    repeat (4) begin
      tick(); #1 check("f_fault_sticky", 32'(act_vec_f), 32'(E_FAULT));
    end
    rst_f = 1'b1;
    #1 check("f_fault_cleared", 32'(act_vec_f), 32'd0);
    f_done = 1'b1;
  end

  initial begin
    int stall;
    stall = 0;
    bus.i_Start = 0; bus.i_Halt = 0; bus.i_Mem_R = 0; bus.i_Exec_Gate = 0; bus.i_Exec_Done = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("reset_outputs", 32'(act_vec), 32'd0);
    check("reset_count", 32'(bus.o_Instr_Count), 32'd0);

    bus.i_Start = 1'b1; bus.i_Mem_R = 1'b1;
    tick(); bus.i_Start = 1'b0; #1 check("fetch1", 32'(act_vec), 32'(E_F1));
    tick(); #1 check("fetch2", 32'(act_vec), 32'(E_F2));
    tick(); #1 check("fetch3", 32'(act_vec), 32'(E_F3));
    check("count_before_decode", 32'(bus.o_Instr_Count), 32'd0);
    tick(); #1 check("decode", 32'(act_vec), 32'(E_DEC));
    check("count_after_fetch", 32'(bus.o_Instr_Count), 32'd1);
    tick(); bus.i_Exec_Gate = 4'b0111; #1 check("exec_alu_only", 32'(act_vec), 32'(E_ALU));
    tick(); bus.i_Exec_Gate = 4'b0001; #1 check("exec_pc_conflict", 32'(act_vec), 32'(E_PC_CONF));
    tick(); bus.i_Exec_Gate = 4'b0000; bus.i_Exec_Done = 1'b1;
    #1 check("exec_no_conflict", 32'(act_vec), 32'd0);
    tick(); bus.i_Exec_Done = 1'b0; bus.i_Mem_R = 1'b0;
    #1 check("fetch1_no_bubble", 32'(act_vec), 32'(E_F1));

    for (int i = 0; i < 6; i++) begin
      tick(); bus.i_Halt = (i == 0); bus.i_Mem_R = (i == 5);
      #1 check("fetch2_held", 32'(act_vec), 32'(E_F2));
    end
    tick(); bus.i_Mem_R = 1'b0; #1 check("fetch3_late", 32'(act_vec), 32'(E_F3));
    tick(); #1 check("decode_late", 32'(act_vec), 32'(E_DEC));
    tick(); bus.i_Exec_Done = 1'b1;
    tick(); bus.i_Exec_Done = 1'b0; #1 check("halt_to_idle", 32'(act_vec), 32'd0);
    repeat (3) begin
      tick(); #1 check("halt_stays_idle", 32'(act_vec), 32'd0);
    end

    force dut.instr_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    #1 release dut.instr_count_q;
    bus.i_Start = 1'b1; bus.i_Mem_R = 1'b1;
    tick(); bus.i_Start = 1'b0; #1 check("resume_fetch1", 32'(act_vec), 32'(E_F1));
    tick();
    tick(); #1 check("count_preload", 32'(bus.o_Instr_Count), 32'hFFFF);
    tick(); #1 check("count_wrap", 32'(bus.o_Instr_Count), 32'd0);
    tick(); bus.i_Exec_Done = 1'b1;
    tick(); bus.i_Exec_Done = 1'b0;
    tick();
    tick(); #1 check("fetch3_before_reset", 32'(act_vec), 32'(E_F3));
    #1 rst = 1'b1;
    #1 check("async_reset_outputs", 32'(act_vec), 32'd0);
    check("async_reset_count", 32'(bus.o_Instr_Count), 32'd0);
    tick(); tick(); rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      tick();
      if (rst) rst = 1'b0;
      else if (m_ph == M_FAULT && $urandom_range(0, 3) == 0) rst = 1'b1;
      bus.i_Start     = 1'($urandom_range(0, 1));
      bus.i_Halt      = ($urandom_range(0, 15) == 0);
      bus.i_Exec_Done = ($urandom_range(0, 3) == 0);
      bus.i_Exec_Gate = 4'($urandom);
      if (stall > 0) begin
        stall--;
        bus.i_Mem_R = 1'b0;
      end else begin
        bus.i_Mem_R = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) == 0) stall = 20;
      end
      if (!rst && $urandom_range(0, 299) == 0) #2 rst = 1'b1;
    end
    tick(); rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 100 && !f_done; i++) @(posedge clk);
    check("fault_sequence_finished", 32'(f_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
